// File: rtl/text_ram_multichannel_pkg.sv
// text_ram_multichannel_pkg: ASCII codes, column positions and digit helpers for the channel text rows
package text_ram_multichannel_pkg;
    localparam logic [6:0] SPACE  = 7'h20;
    localparam logic [6:0] DASH   = 7'h2D;
    localparam logic [6:0] DOT    = 7'h2E;
    localparam logic [6:0] CHAR_V = 7'h56;
    localparam logic [6:0] DIGIT0 = 7'h30;
    localparam logic [6:0] QMARK  = 7'h3F;
    localparam logic [4:0] COL_V0    = 5'd0;
    localparam logic [4:0] COL_TENS  = 5'd1;
    localparam logic [4:0] COL_UNITS = 5'd2;
    localparam logic [4:0] COL_SEP   = 5'd4;
    localparam logic [4:0] COL_D3    = 5'd6;
    localparam logic [4:0] COL_DP    = 5'd7;
    localparam logic [4:0] COL_D2    = 5'd8;
    localparam logic [4:0] COL_D1    = 5'd9;
    localparam logic [4:0] COL_D0    = 5'd10;
    localparam logic [4:0] COL_V1    = 5'd12;
    function automatic logic [6:0] bcd_to_ascii(input logic [3:0] d);
        return (d > 4'd9) ? QMARK : DIGIT0 + {3'b000, d};
    endfunction
    function automatic logic [6:0] row_tens(input logic [6:0] n);
        return DIGIT0 + n / 7'd10;
    endfunction
    function automatic logic [6:0] row_units(input logic [6:0] n);
        return DIGIT0 + n % 7'd10;
    endfunction
endpackage

// File: rtl/text_ram_multichannel_refresh_tick.sv
// refresh_tick: free-running prescaler, tick is high during the last count of each window
module refresh_tick #(
    parameter int REFRESH_CYC = 65_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = $clog2(REFRESH_CYC);
    localparam logic [W-1:0] LAST = W'(REFRESH_CYC - 1);
    logic [W-1:0] cnt;
    assign tick = cnt == LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/text_ram_multichannel.sv
// text_ram_multichannel: double-buffered per-channel BCD readings rendered as "Vnn - d.ddd V" ASCII rows
module text_ram_multichannel
    import text_ram_multichannel_pkg::*;
#(
    parameter int NUM_CH      = 13,
    parameter int REFRESH_CYC = 65_000_000,
    parameter int DP_EN       = 1,
    parameter int STALE_DASH  = 1,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [15:0]   wr_bcd,
    input  logic [CW-1:0] text_row,
    input  logic [3:0]    text_col,
    output logic [6:0]    char_code,
    output logic          refresh
);
    logic [15:0] wbank [NUM_CH];
    logic [15:0] dbank [NUM_CH];
    logic [NUM_CH-1:0] fresh, dstale, hit;
    logic tick, row_ok, stale;
    logic [CW-1:0] rd;
    logic [4:0] col;
    logic [6:0] n, ch;
    logic [15:0] bcd;

    refresh_tick #(.REFRESH_CYC(REFRESH_CYC)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) hit[i] = wr_en && (wr_ch == CW'(i));
    end

    assign row_ok = text_row <= CW'(NUM_CH - 1);
    assign rd     = row_ok ? text_row : '0;
    assign bcd    = dbank[rd];
    assign stale  = (STALE_DASH != 0) && dstale[rd];
    assign n      = 7'(rd) + 7'd1;
    // without a decimal point every column from 7 on maps to the next layout slot
    assign col    = {1'b0, text_col} + ((DP_EN == 0 && text_col >= 4'd7) ? 5'd1 : 5'd0);

    always_comb begin
        ch = SPACE;
        if (row_ok) begin
            case (col)
                COL_V0, COL_V1: ch = CHAR_V;
                COL_TENS:       ch = row_tens(n);
                COL_UNITS:      ch = row_units(n);
                COL_SEP:        ch = DASH;
                COL_D3:         ch = stale ? DASH : bcd_to_ascii(bcd[15:12]);
                COL_DP:         ch = DOT;
                COL_D2:         ch = stale ? DASH : bcd_to_ascii(bcd[11:8]);
                COL_D1:         ch = stale ? DASH : bcd_to_ascii(bcd[7:4]);
                COL_D0:         ch = stale ? DASH : bcd_to_ascii(bcd[3:0]);
                default:        ch = SPACE;
            endcase
        end
    end

    // a write landing on the snapshot edge goes straight into the display bank and stays fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wbank[i] <= '0;
                dbank[i] <= '0;
            end
            fresh     <= '0;
            dstale    <= '1;
            refresh   <= 1'b0;
            char_code <= SPACE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i]) wbank[i] <= wr_bcd;
                if (tick) dbank[i] <= hit[i] ? wr_bcd : wbank[i];
            end
            fresh <= (tick ? '0 : fresh) | hit;
            if (tick) dstale <= ~(fresh | hit);
            refresh   <= tick;
            char_code <= ch;
        end
    end
endmodule

// File: tb/tb_text_ram_multichannel.sv
// tb_text_ram_multichannel: table vectors, corner sequences and random traffic against a string-level model
module tb_text_ram_multichannel;
    logic clk = 1'b0;
    logic rst_n, wr_en;
    logic [3:0] wr_ch, text_row, text_col;
    logic [15:0] wr_bcd;
    logic [6:0] char_code;
    logic refresh;

    text_ram_multichannel #(.NUM_CH(13), .REFRESH_CYC(16), .DP_EN(1), .STALE_DASH(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_bcd(wr_bcd),
        .text_row(text_row), .text_col(text_col), .char_code(char_code), .refresh(refresh)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] row; logic [3:0] col; logic [6:0] exp; } vec_t;
    vec_t tbl [15];

    logic [15:0] m_w [13];
    logic [15:0] m_d [13];
    bit m_fresh [13];
    bit m_stale [13];
    int ecount, total, bad;
    logic [6:0] e_char;
    logic e_ref;

    function automatic string dstr(logic [3:0] d, bit st);
        if (st) return "-";
        if (d > 9) return "?";
        return $sformatf("%0d", d);
    endfunction

    function automatic logic [6:0] model_char(int r, int c);
        string s;
        logic [15:0] v;
        if (r >= 13) return 7'h20;
        v = m_d[r];
        s = {"V", $sformatf("%02d", r + 1), " - ", dstr(v[15:12], m_stale[r]), ".",
             dstr(v[11:8], m_stale[r]), dstr(v[7:4], m_stale[r]), dstr(v[3:0], m_stale[r]), " V"};
        if (c >= s.len()) return 7'h20;
        return 7'(s[c]);
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset;
        for (int i = 0; i < 13; i++) begin
            m_w[i] = '0; m_d[i] = '0; m_fresh[i] = 0; m_stale[i] = 1;
        end
        ecount = 0;
    endtask

    task automatic step;
        bit hit, snap;
        @(posedge clk);
        ecount++;
        e_char = model_char(int'(text_row), int'(text_col));
        snap = (ecount % 16) == 0;
        hit = wr_en && wr_ch < 13;
        if (hit) m_w[wr_ch] = wr_bcd;
        if (snap)
            for (int i = 0; i < 13; i++) begin
                m_d[i] = m_w[i];
                m_stale[i] = !(m_fresh[i] || (hit && int'(wr_ch) == i));
                m_fresh[i] = 0;
            end
        if (hit) m_fresh[wr_ch] = 1;
        e_ref = snap;
        #1;
    endtask

    task automatic read_chk(int r, int c, logic [6:0] exp, string nm);
        text_row = 4'(r);
        text_col = 4'(c);
        step();
        chk(nm, 16'(char_code), 16'(exp));
    endtask

    task automatic wait_refresh(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!refresh && n < 40);
        if (!refresh) begin
            total++;
            bad++;
            $display("FAIL refresh_timeout: no pulse within %0d cycles", n);
        end
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_char", 16'(char_code), 16'h20);
        chk("rst_refresh", 16'(refresh), 16'h0);
        @(posedge clk);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        string s;
        int n;
        s = "V03 - 3.297 V";
        for (int c = 0; c < 13; c++) tbl[c] = '{4'd2, 4'(c), 7'(s[c])};
        tbl[13] = '{4'd13, 4'd0, 7'h20};
        tbl[14] = '{4'd2, 4'd13, 7'h20};
        total = 0; bad = 0;
        rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_bcd = '0; text_row = '0; text_col = '0;
        apply_reset();
        read_chk(0, 6, 7'h2D, "rst_dash");

        wr_en = 1'b1; wr_ch = 4'd2; wr_bcd = 16'h3297;
        step();
        wr_en = 1'b0;
        read_chk(2, 6, 7'h2D, "pre_refresh_d3");
        read_chk(2, 7, 7'h2E, "pre_refresh_dp");
        read_chk(2, 8, 7'h2D, "pre_refresh_d2");
        wait_refresh(n);
        for (int k = 0; k < 15; k++)
            read_chk(int'(tbl[k].row), int'(tbl[k].col), tbl[k].exp, $sformatf("tbl%0d", k));

        wait_refresh(n);
        wait_refresh(n);
        chk("refresh_period", 16'(n), 16'd16);
        read_chk(2, 8, 7'h2D, "empty_window_dash");
        read_chk(2, 7, 7'h2E, "empty_window_dp");

        while (((ecount + 1) % 16) != 0) step();
        wr_en = 1'b1; wr_ch = 4'd12; wr_bcd = 16'h0089;
        step();
        wr_en = 1'b0;
        chk("snap_refresh", 16'(refresh), 16'h1);
        read_chk(12, 1, 7'h31, "snap_tens");
        read_chk(12, 2, 7'h33, "snap_units");
        read_chk(12, 6, 7'h30, "snap_d3");
        read_chk(12, 8, 7'h30, "snap_d2");
        read_chk(12, 9, 7'h38, "snap_d1");
        read_chk(12, 10, 7'h39, "snap_d0");
        wait_refresh(n);
        read_chk(12, 9, 7'h38, "snap_still_fresh");

        wr_en = 1'b1; wr_ch = 4'd13; wr_bcd = 16'h1111;
        step();
        wr_ch = 4'd5; wr_bcd = 16'h1A2B;
        step();
        wr_en = 1'b0;
        wait_refresh(n);
        read_chk(5, 6, 7'h31, "bcd_digit");
        read_chk(5, 8, 7'h3F, "bcd_nibble_a");
        read_chk(5, 10, 7'h3F, "bcd_nibble_b");
        read_chk(13, 0, 7'h20, "bad_row");
        read_chk(0, 6, 7'h2D, "bad_ch_ignored");

        wr_en = 1'b1; wr_ch = 4'd3; wr_bcd = 16'h4444;
        step();
        wr_en = 1'b0;
        read_chk(3, 0, 7'h56, "pre_rst_v");
        rst_n = 1'b0;
        #1 chk("async_rst_char", 16'(char_code), 16'h20);
        apply_reset();
        wait_refresh(n);
        chk("rst_refresh_delay", 16'(n), 16'd16);
        read_chk(3, 6, 7'h2D, "rst_write_lost");

        for (int k = 0; k < 300; k++) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_ch = 4'($urandom_range(0, 14));
            wr_bcd = 16'($urandom);
            text_row = 4'($urandom_range(0, 15));
            text_col = 4'($urandom_range(0, 15));
            step();
            chk($sformatf("rnd_char%0d", k), 16'(char_code), 16'(e_char));
            chk($sformatf("rnd_refresh%0d", k), 16'(refresh), 16'(e_ref));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
